// File: rtl/led_bank_driver_pkg.sv
// Shared definitions for the LED bank driver: register addresses,
// display-mode encodings and the blink-select clamp helper.
package led_bank_driver_pkg;

  // Register map of the peripheral
  localparam logic [1:0] LED_ADDR_LO   = 2'd0;
  localparam logic [1:0] LED_ADDR_HI   = 2'd1;
  localparam logic [1:0] LED_ADDR_CTRL = 2'd2;
  localparam logic [1:0] LED_ADDR_DUTY = 2'd3;

  // Field positions inside the ctrl register
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_SEL_LSB  = 4;

  // Display modes held in ctrl[1:0]
  typedef enum logic [1:0] {
    LED_MODE_STATIC = 2'b00,
    LED_MODE_BLINK  = 2'b01,
    LED_MODE_PWM    = 2'b10,
    LED_MODE_BOTH   = 2'b11
  } led_mode_e;

  // Keep a blink bit selection inside the blink counter width
  function automatic logic [3:0] clamp_blink_sel(input logic [3:0] sel, input int width);
    if (int'(sel) >= width) begin
      return 4'(width - 1);
    end
    return sel;
  endfunction

endpackage

// File: rtl/led_bank_driver_if.sv
// CPU I/O bus seen by the LED bank driver: chip-select qualified
// read/write with a registered read-data return path.
interface led_bank_driver_if #(
  parameter int BUS_W = 16
);
  logic             ledcs;
  logic             ledwrite;
  logic [1:0]       ledaddr;
  logic [BUS_W-1:0] ledwdata;
  logic [BUS_W-1:0] ledrdata;

  modport master (
    output ledcs,
    output ledwrite,
    output ledaddr,
    output ledwdata,
    input  ledrdata
  );

  modport slave (
    input  ledcs,
    input  ledwrite,
    input  ledaddr,
    input  ledwdata,
    output ledrdata
  );
endinterface

// File: rtl/led_bank_driver_timebase.sv
// Timebase for the LED bank: a prescaler producing a one-cycle tick,
// plus the PWM and blink counters advanced by that tick.
module led_timebase
  import led_bank_driver_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 100,
  parameter int BLINK_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [3:0]          blink_sel,
  output logic                tick,
  output logic                pwm_on,
  output logic                blink_on
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic [3:0]          sel_eff;

  assign tick = (presc_q == PRESC_LAST);

  // Counter next-state: clear beats a coincident tick so a new mode starts on
  always_comb begin
    presc_d     = presc_q;
    pwm_cnt_d   = pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    if (clear) begin
      presc_d     = '0;
      pwm_cnt_d   = '0;
      blink_cnt_d = '0;
    end else if (tick) begin
      presc_d     = '0;
      pwm_cnt_d   = pwm_cnt_q + 1'b1;
      blink_cnt_d = blink_cnt_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Phase decode: full-scale duty is solid on, blink is on while the selected bit is low
  always_comb begin
    sel_eff  = clamp_blink_sel(blink_sel, BLINK_W);
    pwm_on   = (duty == '1) || (pwm_cnt_q < duty);
    blink_on = ~blink_cnt_q[sel_eff];
  end

endmodule

// File: rtl/led_bank_driver.sv
// Memory-mapped LED bank driver: pattern/ctrl/duty register file,
// registered read-back and a registered, mode-gated LED output stage.
module led_bank_driver
  import led_bank_driver_pkg::*;
#(
  parameter int NUM_LEDS = 24,
  parameter int BUS_W    = 16,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 100,
  parameter int BLINK_W  = 16
) (
  input  logic                ledclk,
  input  logic                ledrst,
  led_bank_driver_if.slave    bus,
  output logic [NUM_LEDS-1:0] ledout
);

  // Pattern is kept two bus words wide; bits above NUM_LEDS are forced to 0
  localparam int PW = 2 * BUS_W;
  localparam logic [PW-1:0] PAT_MASK = {PW{1'b1}} >> (PW - NUM_LEDS);

  logic [PW-1:0]       pattern_q, pattern_d;
  led_mode_e           mode_q, mode_d;
  logic [3:0]          sel_q, sel_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [BUS_W-1:0]    rdata_q, rdata_d;
  logic [NUM_LEDS-1:0] ledout_q, ledout_d;
  logic                clear;
  logic                pwm_on;
  logic                blink_on;

  led_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE),
    .BLINK_W  (BLINK_W)
  ) u_timebase (
    .clk       (ledclk),
    .rst       (ledrst),
    .clear     (clear),
    .duty      (duty_q),
    .blink_sel (sel_q),
    .tick      (),
    .pwm_on    (pwm_on),
    .blink_on  (blink_on)
  );

  // Register writes and read mux; a ctrl write also restarts the timebase
  always_comb begin
    pattern_d = pattern_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    duty_d    = duty_q;
    rdata_d   = rdata_q;
    clear     = 1'b0;
    if (bus.ledcs && bus.ledwrite) begin
      case (bus.ledaddr)
        LED_ADDR_LO:   pattern_d[BUS_W-1:0]  = bus.ledwdata & PAT_MASK[BUS_W-1:0];
        LED_ADDR_HI:   pattern_d[PW-1:BUS_W] = bus.ledwdata & PAT_MASK[PW-1:BUS_W];
        LED_ADDR_CTRL: begin
          mode_d = led_mode_e'(bus.ledwdata[CTRL_MODE_LSB +: 2]);
          sel_d  = bus.ledwdata[CTRL_SEL_LSB +: 4];
          clear  = 1'b1;
        end
        default:       duty_d = bus.ledwdata[PWM_BITS-1:0];
      endcase
    end else if (bus.ledcs) begin
      case (bus.ledaddr)
        LED_ADDR_LO:   rdata_d = pattern_q[BUS_W-1:0];
        LED_ADDR_HI:   rdata_d = pattern_q[PW-1:BUS_W];
        LED_ADDR_CTRL: begin
          rdata_d = '0;
          rdata_d[CTRL_MODE_LSB +: 2] = mode_q;
          rdata_d[CTRL_SEL_LSB +: 4]  = sel_q;
        end
        default:       rdata_d = BUS_W'(duty_q);
      endcase
    end
  end

  // Output gating by display mode
  always_comb begin
    ledout_d = pattern_q[NUM_LEDS-1:0];
    case (mode_q)
      LED_MODE_BLINK: ledout_d = blink_on ? pattern_q[NUM_LEDS-1:0] : '0;
      LED_MODE_PWM:   ledout_d = pwm_on ? pattern_q[NUM_LEDS-1:0] : '0;
      LED_MODE_BOTH:  ledout_d = (blink_on && pwm_on) ? pattern_q[NUM_LEDS-1:0] : '0;
      default:        ledout_d = pattern_q[NUM_LEDS-1:0];
    endcase
  end

  // Register file, read-data and LED output registers
  always_ff @(posedge ledclk or posedge ledrst) begin
    if (ledrst) begin
      pattern_q <= '0;
      mode_q    <= LED_MODE_STATIC;
      sel_q     <= '0;
      duty_q    <= '0;
      rdata_q   <= '0;
      ledout_q  <= '0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      duty_q    <= duty_d;
      rdata_q   <= rdata_d;
      ledout_q  <= ledout_d;
    end
  end

  assign bus.ledrdata = rdata_q;
  assign ledout       = ledout_q;

endmodule

// File: tb/tb_led_bank_driver.sv
// Directed bench for led_bank_driver: one instance with PRESCALE=4
// (blink timing) and one with PRESCALE=1 (PWM timing), both fed the
// same bus stimulus.
module tb_led_bank_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [23:0] ledout_a;
  logic [23:0] ledout_b;
  int          passed = 0;
  int          total  = 0;

  led_bank_driver_if #(.BUS_W(16)) bus_a ();
  led_bank_driver_if #(.BUS_W(16)) bus_b ();

  assign bus_a.ledcs    = cs;
  assign bus_a.ledwrite = wr;
  assign bus_a.ledaddr  = addr;
  assign bus_a.ledwdata = wdata;
  assign bus_b.ledcs    = cs;
  assign bus_b.ledwrite = wr;
  assign bus_b.ledaddr  = addr;
  assign bus_b.ledwdata = wdata;

  led_bank_driver #(
    .NUM_LEDS (24), .BUS_W (16), .PWM_BITS (8), .PRESCALE (4), .BLINK_W (16)
  ) dut_a (
    .ledclk (clk), .ledrst (rst), .bus (bus_a), .ledout (ledout_a)
  );

  led_bank_driver #(
    .NUM_LEDS (24), .BUS_W (16), .PWM_BITS (8), .PRESCALE (1), .BLINK_W (16)
  ) dut_b (
    .ledclk (clk), .ledrst (rst), .bus (bus_b), .ledout (ledout_b)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge,
  // and the task returns at the negedge after it.
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] da, output logic [15:0] db);
    cs = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    da = bus_a.ledrdata;
    db = bus_b.ledrdata;
    $display("read  addr=%0d data=%h", a, da);
  endtask

  task automatic test_reset();
    logic [15:0] ra, rb;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 16'h0000;
    repeat (3) @(negedge clk);
    total++;
    if (ledout_a !== 24'h0 || ledout_b !== 24'h0)
      $display("FAIL reset_ledout got %h/%h want 000000", ledout_a, ledout_b);
    else passed++;
    total++;
    if (bus_a.ledrdata !== 16'h0)
      $display("FAIL reset_rdata got %h want 0000", bus_a.ledrdata);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), ra, rb);
      total++;
      if (ra !== 16'h0 || rb !== 16'h0)
        $display("FAIL reset_reg%0d got %h/%h want 0000", i, ra, rb);
      else passed++;
    end
  endtask

  task automatic test_static();
    logic [15:0] ra, rb;
    bus_write(2'd2, 16'h0000);
    bus_write(2'd0, 16'hA5A5);
    bus_write(2'd1, 16'h00C3);
    total++;
    if (ledout_a !== 24'h00A5A5)
      $display("FAIL static_latency got %h want 00a5a5", ledout_a);
    else passed++;
    @(negedge clk);
    total++;
    if (ledout_a !== 24'hC3A5A5 || ledout_b !== 24'hC3A5A5)
      $display("FAIL static_out got %h/%h want c3a5a5", ledout_a, ledout_b);
    else passed++;
    bus_read(2'd1, ra, rb);
    total++;
    if (ra !== 16'h00C3)
      $display("FAIL static_read_hi got %h want 00c3", ra);
    else passed++;
  endtask

  task automatic test_hi_mask();
    logic [15:0] ra, rb;
    bus_write(2'd1, 16'hFFFF);
    @(negedge clk);
    total++;
    if (ledout_a !== 24'hFFA5A5)
      $display("FAIL hi_mask_out got %h want ffa5a5", ledout_a);
    else passed++;
    bus_read(2'd1, ra, rb);
    total++;
    if (ra !== 16'h00FF)
      $display("FAIL hi_mask_read got %h want 00ff", ra);
    else passed++;
  endtask

  task automatic test_ctrl_duty_readback();
    logic [15:0] ra, rb;
    bus_write(2'd2, 16'hFFFF);
    bus_read(2'd2, ra, rb);
    total++;
    if (ra !== 16'h00F3)
      $display("FAIL ctrl_read got %h want 00f3", ra);
    else passed++;
    bus_write(2'd3, 16'h1240);
    bus_read(2'd3, ra, rb);
    total++;
    if (ra !== 16'h0040)
      $display("FAIL duty_read got %h want 0040", ra);
    else passed++;
    bus_write(2'd2, 16'h0000);
  endtask

  task automatic test_no_cs();
    logic [15:0] ra, rb;
    bus_read(2'd0, ra, rb);
    cs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr = 1'(i % 2); addr = 2'(i); wdata = 16'(16'h1357 * (i + 1));
      @(negedge clk);
    end
    wr = 1'b0;
    total++;
    if (ledout_a !== 24'hFFA5A5)
      $display("FAIL nocs_ledout got %h want ffa5a5", ledout_a);
    else passed++;
    total++;
    if (bus_a.ledrdata !== 16'hA5A5)
      $display("FAIL nocs_rdata_hold got %h want a5a5", bus_a.ledrdata);
    else passed++;
    // Reads with cs active update rdata only
    cs = 1'b1; wr = 1'b0; addr = 2'd1; wdata = 16'h0F0F;
    @(negedge clk);
    total++;
    if (bus_a.ledrdata !== 16'h00FF)
      $display("FAIL cs_read_update got %h want 00ff", bus_a.ledrdata);
    else passed++;
    addr = 2'd3; wdata = 16'hF0F0;
    @(negedge clk);
    cs = 1'b0;
    total++;
    if (bus_a.ledrdata !== 16'h0040 || ledout_a !== 24'hFFA5A5)
      $display("FAIL cs_read_side got rdata %h ledout %h want 0040 ffa5a5",
               bus_a.ledrdata, ledout_a);
    else passed++;
    bus_read(2'd0, ra, rb);
    total++;
    if (ra !== 16'hA5A5)
      $display("FAIL nocs_pattern got %h want a5a5", ra);
    else passed++;
  endtask

  task automatic test_blink();
    int errs = 0;
    int ons  = 0;
    logic [23:0] exp;
    bus_write(2'd0, 16'hFFFF);
    bus_write(2'd1, 16'hFFFF);
    bus_write(2'd2, 16'h0011);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      exp = (((i / 8) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
      if (ledout_a !== exp) errs++;
      if (ledout_a === 24'hFFFFFF) ons++;
    end
    total++;
    if (errs != 0 || ons != 24)
      $display("FAIL blink_pattern got %0d errors %0d on want 0 errors 24 on", errs, ons);
    else passed++;
    total++;
    if (ledout_a !== 24'h0)
      $display("FAIL blink_mid_off got %h want 000000", ledout_a);
    else passed++;
    bus_write(2'd2, 16'h0011);
    errs = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      exp = (j < 8) ? 24'hFFFFFF : 24'h000000;
      if (j == 0) begin
        total++;
        if (ledout_a !== 24'hFFFFFF)
          $display("FAIL blink_restart got %h want ffffff", ledout_a);
        else passed++;
      end
      if (ledout_a !== exp) errs++;
    end
    total++;
    if (errs != 0)
      $display("FAIL blink_after_restart got %0d errors want 0", errs);
    else passed++;
  endtask

  task automatic test_pwm();
    int errs = 0;
    int ons  = 0;
    logic [23:0] exp;
    bus_write(2'd3, 16'h0040);
    bus_write(2'd2, 16'h0002);
    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      exp = ((j % 256) < 64) ? 24'hFFFFFF : 24'h000000;
      if (ledout_b !== exp) errs++;
      if (ledout_b === 24'hFFFFFF) ons++;
    end
    total++;
    if (errs != 0 || ons != 128)
      $display("FAIL pwm64 got %0d errors %0d on want 0 errors 128 on", errs, ons);
    else passed++;
    bus_write(2'd3, 16'h0000);
    ons = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (ledout_b !== 24'h0) ons++;
    end
    total++;
    if (ons != 0)
      $display("FAIL pwm0 got %0d on cycles want 0", ons);
    else passed++;
    bus_write(2'd3, 16'h00FF);
    ons = 0;
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (ledout_b === 24'hFFFFFF) ons++;
    end
    total++;
    if (ons != 256)
      $display("FAIL pwm255 got %0d on cycles want 256", ons);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [15:0] ra, rb;
    bus_write(2'd3, 16'h0040);
    bus_write(2'd2, 16'h0002);
    repeat (10) @(negedge clk);
    bus_read(2'd0, ra, rb);
    total++;
    if (rb !== 16'hFFFF || ledout_b !== 24'hFFFFFF)
      $display("FAIL pre_reset got rdata %h ledout %h want ffff ffffff", rb, ledout_b);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ledout_a !== 24'h0 || ledout_b !== 24'h0)
      $display("FAIL async_ledout got %h/%h want 000000", ledout_a, ledout_b);
    else passed++;
    total++;
    if (bus_a.ledrdata !== 16'h0 || bus_b.ledrdata !== 16'h0)
      $display("FAIL async_rdata got %h/%h want 0000", bus_a.ledrdata, bus_b.ledrdata);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(3 - i), ra, rb);
      total++;
      if (ra !== 16'h0 || rb !== 16'h0)
        $display("FAIL post_reset_reg%0d got %h/%h want 0000", 3 - i, ra, rb);
      else passed++;
    end
    total++;
    if (ledout_b !== 24'h0)
      $display("FAIL post_reset_ledout got %h want 000000", ledout_b);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_static();
    test_hi_mask();
    test_ctrl_duty_readback();
    test_no_cs();
    test_blink();
    test_pwm();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
